sensor_packet_scheduler: RTL and testbench
==========================================

# sensor_packet_scheduler

Arbitrates the temperature, humidity and motion sensor streams onto the single shared packet framer. It holds one pending sample per channel and issues exactly one framing request at a time. It waits for the framer's completion pulse, or a timeout, before issuing the next request. It sits between the sensor front-ends and `packet_framer`, and drives the framer's per-sensor valid/data inputs.

## Interface
- `DATA_W`, 16, sample width
- `TIMEOUT_CYCLES`, 1024, maximum cycles to wait for `frm_done` (≥ 2)
- `CNT_W`, 8, width of each per-channel drop counter
- `clk`  in  1  clock; reset rst_n, asynchronous, active-low; clock clk
- `rst_n`  in  1  asynchronous active-low reset
- `temp_valid` / `hum_valid` / `motion_valid`  in  1 each  single-cycle sample strobes
- `temp_data` / `hum_data` / `motion_data`  in  DATA_W each  sample values, qualified by strobe
- `enable`  in  1  allows new grants
- `motion_priority`  in  1  1 = motion strictly preempts round-robin
- `frm_done`  in  1  framer packet-sent pulse
- `err_clr`  in  1  clears `timeout_err`
- `frm_valid`  out  3  one-hot request pulse to framer: bit0 temp, bit1 hum, bit2 motion
- `frm_data`  out  DATA_W  sample for the granted channel, held until next grant
- `busy`  out  1  request in flight (state WAIT)
- `pending`  out  3  per-channel pending flags
- `drop_cnt_temp` / `drop_cnt_hum` / `drop_cnt_motion`  out  CNT_W each  saturating overwrite counts
- `pkt_count`  out  16  completed packets, wraps
- `timeout_err`  out  1  sticky timeout flag

## Operation
- Pending buffer: each channel has 1 flag and 1 DATA_W register.
  - Strobe sets the flag and loads the data.
  - Strobe while the flag is already set and not consumed this cycle: data is overwritten with the newest sample and the drop counter increments, saturating at 2^CNT_W−1.
  - Strobe in the same cycle the channel is granted: the flag stays set with the new data, and no drop is counted.
- FSM states: IDLE, WAIT.
  - IDLE: if `enable` and any flag is set, select a channel, then at that edge:
    - drive `frm_valid` = one-hot(sel) and `frm_data` = data[sel]
    - clear the flag
    - `last_grant` ← sel
    - timer ← 0
    - → WAIT
  - WAIT:
    - `frm_valid` ← 0 and timer increments.
    - `frm_done` → IDLE, `pkt_count`+1.
    - Else, timer == TIMEOUT_CYCLES−1 → IDLE, `timeout_err` ← 1, `pkt_count` unchanged.
- Selection rule:
  - If `motion_priority` and motion is pending, grant motion.
  - Otherwise round-robin, searching from `last_grant`+1 in the order temp → hum → motion → temp.
  - `last_grant` resets to motion, so temp wins the first tie.
- `frm_done` in IDLE is ignored.
- `enable` low blocks new grants only. An in-flight request completes normally, and strobes are still captured.
- `err_clr` clears `timeout_err`. A simultaneous timeout wins, leaving `timeout_err` = 1.

## Timing
- All outputs are registered.
- Reset values:
  - `frm_valid`=0, `frm_data`=0, `busy`=0, `pending`=0
  - drop counters=0, `pkt_count`=0, `timeout_err`=0
  - state=IDLE, `last_grant`=motion
- Latency: strobe sampled at edge N → `pending` high after N → `frm_valid` pulse high for exactly one cycle after edge N+1 → `busy` high from edge N+1.
- `frm_done` sampled at edge M → `busy` low after M → the next grant can occur at edge M+1, so `frm_valid` pulses are separated by at least 1 idle cycle.
- Timeout: `busy` falls at the edge where the timer equals TIMEOUT_CYCLES−1, i.e. TIMEOUT_CYCLES cycles after the grant edge.
- Reset mid-WAIT: everything returns to reset values immediately, and pending samples are lost.

## Test plan
- Single path: temp_valid with 0x1234 → one-cycle `frm_valid`=3'b001 with `frm_data`=0x1234 two edges after the strobe. `frm_done` 5 cycles later → `busy`=0, `pkt_count`=1.
- Round-robin: all three strobe together with `motion_priority`=0 and `frm_done` returned each time → grant order temp, hum, motion. A repeat burst gives the same order.
- Priority: `motion_priority`=1, hum and motion pending, last grant temp → motion is granted first, then hum.
- Overwrite: three temp strobes (0x0001, 0x0002, 0x0003) while busy → drop_cnt_temp=2 and the next grant carries 0x0003. 300 strobes with CNT_W=8 → saturates at 255.
- Timeout: with TIMEOUT_CYCLES=16, grant and never return `frm_done` → `busy` falls 16 cycles after the grant, `timeout_err`=1, `pkt_count`=0. `err_clr` → `timeout_err`=0.
- Enable/reset: `enable`=0 with samples pending → no `frm_valid` and `pending`=3'b111. `enable`=1 → grants resume. Assert `rst_n` low mid-WAIT → all outputs return to reset values.

Source files
------------

// File: rtl/sensor_packet_scheduler.sv
// sensor_packet_scheduler
//
// Shares one packet framer between the temperature, humidity and motion
// sensor streams. Each channel buffers a single pending sample. The block
// issues one framing request at a time. It then waits for the framer's
// completion pulse, or for a timeout, before it grants again.
//
// Parameters
//   DATA_W          sample width
//   TIMEOUT_CYCLES  cycles to wait for frm_done before giving up (>= 2)
//   CNT_W           width of each per-channel drop counter
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   temp/hum/motion_valid, _data  single-cycle sample strobes and values
//   enable                        allows new grants
//   motion_priority               motion pre-empts round-robin when set
//   frm_done                      framer packet-sent pulse
//   err_clr                       clears timeout_err
//   frm_valid                     one-hot request pulse (bit0 temp, bit1 hum, bit2 motion)
//   frm_data                      sample of the granted channel, held until the next grant
//   busy                          request in flight
//   pending                       per-channel pending flags
//   drop_cnt_temp/hum/motion      saturating overwrite counters
//   pkt_count                     completed packets (wraps)
//   timeout_err                   sticky timeout flag
module sensor_packet_scheduler #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              temp_valid,
  input  logic [DATA_W-1:0] temp_data,
  input  logic              hum_valid,
  input  logic [DATA_W-1:0] hum_data,
  input  logic              motion_valid,
  input  logic [DATA_W-1:0] motion_data,
  input  logic              enable,
  input  logic              motion_priority,
  input  logic              frm_done,
  input  logic              err_clr,
  output logic [2:0]        frm_valid,
  output logic [DATA_W-1:0] frm_data,
  output logic              busy,
  output logic [2:0]        pending,
  output logic [CNT_W-1:0]  drop_cnt_temp,
  output logic [CNT_W-1:0]  drop_cnt_hum,
  output logic [CNT_W-1:0]  drop_cnt_motion,
  output logic [15:0]       pkt_count,
  output logic              timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] CH_TEMP   = 2'd0;
  localparam logic [1:0] CH_HUM    = 2'd1;
  localparam logic [1:0] CH_MOTION = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state, state_next;

  logic [2:0]        strobe;
  logic [DATA_W-1:0] sample_in  [3];
  logic [DATA_W-1:0] sample_buf [3];
  logic [2:0]        flags;
  logic [CNT_W-1:0]  drop_cnt   [3];
  logic [1:0]        last_grant;
  logic [TMR_W-1:0]  timer;

  logic       grant;
  logic [1:0] sel;
  logic [1:0] rr_sel;
  logic [2:0] consume;
  logic       done_evt;
  logic       timeout_evt;

  assign strobe       = {motion_valid, hum_valid, temp_valid};
  assign sample_in[0] = temp_data;
  assign sample_in[1] = hum_data;
  assign sample_in[2] = motion_data;

  // Round-robin search starts at the channel after the last grant. When
  // nothing is pending the result is ignored because grant stays low.
  always_comb begin
    rr_sel = CH_TEMP;
    case (last_grant)
      CH_TEMP: rr_sel = flags[1] ? CH_HUM    : (flags[2] ? CH_MOTION : CH_TEMP);
      CH_HUM:  rr_sel = flags[2] ? CH_MOTION : (flags[0] ? CH_TEMP   : CH_HUM);
      default: rr_sel = flags[0] ? CH_TEMP   : (flags[1] ? CH_HUM    : CH_MOTION);
    endcase
  end

  // Next-state logic and the per-cycle events it produces
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    done_evt    = 1'b0;
    timeout_evt = 1'b0;
    sel         = (motion_priority && flags[2]) ? CH_MOTION : rr_sel;
    case (state)
      IDLE: begin
        if (enable && (|flags)) begin
          grant      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (frm_done) begin
          done_evt   = 1'b1;
          state_next = IDLE;
        end else if (timer == TMR_LAST) begin
          timeout_evt = 1'b1;
          state_next  = IDLE;
        end
      end
    endcase
    consume = grant ? (3'b001 << sel) : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pending buffers. A strobe on the granted channel refills the slot, so
  // it does not count as a drop. The old sample still goes to the framer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
      for (int c = 0; c < 3; c++) begin
        sample_buf[c] <= '0;
        drop_cnt[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (strobe[c]) begin
          sample_buf[c] <= sample_in[c];
          flags[c]      <= 1'b1;
          if (flags[c] && !consume[c] && (drop_cnt[c] != CNT_MAX)) begin
            drop_cnt[c] <= drop_cnt[c] + 1'b1;
          end
        end else if (consume[c]) begin
          flags[c] <= 1'b0;
        end
      end
    end
  end

  // Request outputs, grant history, wait timer and status counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_valid   <= '0;
      frm_data    <= '0;
      last_grant  <= CH_MOTION;
      timer       <= '0;
      pkt_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      frm_valid <= consume;
      if (grant) begin
        frm_data   <= sample_buf[sel];
        last_grant <= sel;
        timer      <= '0;
      end else if (state == WAIT) begin
        timer <= timer + 1'b1;
      end
      if (done_evt) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (timeout_evt) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

  assign busy            = (state == WAIT);
  assign pending         = flags;
  assign drop_cnt_temp   = drop_cnt[0];
  assign drop_cnt_hum    = drop_cnt[1];
  assign drop_cnt_motion = drop_cnt[2];

endmodule

// File: tb/tb_sensor_packet_scheduler.sv
// tb_sensor_packet_scheduler
//
// Drives sensor_packet_scheduler with a short table of cycle vectors. It
// then runs hand-built sequences for arbitration, overwrite, saturation,
// timeout and enable/reset behaviour, and finally randomized traffic
// compared against a reference model.
module tb_sensor_packet_scheduler;

  localparam int DW = 16;
  localparam int TO = 16;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          temp_valid, hum_valid, motion_valid;
  logic [DW-1:0] temp_data, hum_data, motion_data;
  logic          enable, motion_priority, frm_done, err_clr;
  logic [2:0]    frm_valid;
  logic [DW-1:0] frm_data;
  logic          busy;
  logic [2:0]    pending;
  logic [CW-1:0] drop_cnt_temp, drop_cnt_hum, drop_cnt_motion;
  logic [15:0]   pkt_count;
  logic          timeout_err;

  int n_compared;
  int n_mismatched;

  sensor_packet_scheduler #(
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .temp_valid(temp_valid),
    .temp_data(temp_data),
    .hum_valid(hum_valid),
    .hum_data(hum_data),
    .motion_valid(motion_valid),
    .motion_data(motion_data),
    .enable(enable),
    .motion_priority(motion_priority),
    .frm_done(frm_done),
    .err_clr(err_clr),
    .frm_valid(frm_valid),
    .frm_data(frm_data),
    .busy(busy),
    .pending(pending),
    .drop_cnt_temp(drop_cnt_temp),
    .drop_cnt_hum(drop_cnt_hum),
    .drop_cnt_motion(drop_cnt_motion),
    .pkt_count(pkt_count),
    .timeout_err(timeout_err)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence never returns
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic [2:0]  strobe;
    logic [15:0] td;
    logic [15:0] hd;
    logic [15:0] md;
    logic        done;
    logic [2:0]  e_fv;
    logic [15:0] e_fd;
    logic        e_busy;
    logic [2:0]  e_pend;
    logic [15:0] e_pkt;
  } vec_t;

  function automatic vec_t mk(logic [2:0] s, logic [15:0] td, logic [15:0] hd,
                              logic [15:0] md, logic d, logic [2:0] fv,
                              logic [15:0] fd, logic b, logic [2:0] p,
                              logic [15:0] pk);
    vec_t v;
    v.strobe = s; v.td = td; v.hd = hd; v.md = md; v.done = d;
    v.e_fv = fv; v.e_fd = fd; v.e_busy = b; v.e_pend = p; v.e_pkt = pk;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    temp_valid = 0; hum_valid = 0; motion_valid = 0;
    temp_data = '0; hum_data = '0; motion_data = '0;
    enable = 1; motion_priority = 0; frm_done = 0; err_clr = 0;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic applyStimulus(input vec_t v);
    {motion_valid, hum_valid, temp_valid} = v.strobe;
    temp_data = v.td; hum_data = v.hd; motion_data = v.md;
    frm_done = v.done;
    tick();
    {motion_valid, hum_valid, temp_valid} = 3'b000;
    frm_done = 0;
  endtask

  task automatic pulseDone();
    frm_done = 1;
    tick();
    frm_done = 0;
  endtask

  task automatic strobeCh(input int ch, input logic [15:0] d);
    case (ch)
      0: begin temp_valid = 1; temp_data = d; end
      1: begin hum_valid = 1; hum_data = d; end
      default: begin motion_valid = 1; motion_data = d; end
    endcase
    tick();
    temp_valid = 0; hum_valid = 0; motion_valid = 0;
  endtask

  // Bounded wait for the next frm_valid pulse
  task automatic waitGrant(output logic [2:0] fv, output logic [15:0] fd);
    int n;
    n = 0;
    while (frm_valid == 3'b000 && n < 64) begin
      tick();
      n++;
    end
    fv = frm_valid;
    fd = frm_data;
    if (frm_valid == 3'b000) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL grant_wait: got no frm_valid in %0d cycles, required a grant", n);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_fv"},    32'(frm_valid), 0);
    checkOutput({tag, "_fd"},    32'(frm_data), 0);
    checkOutput({tag, "_busy"},  32'(busy), 0);
    checkOutput({tag, "_pend"},  32'(pending), 0);
    checkOutput({tag, "_dropt"}, 32'(drop_cnt_temp), 0);
    checkOutput({tag, "_droph"}, 32'(drop_cnt_hum), 0);
    checkOutput({tag, "_dropm"}, 32'(drop_cnt_motion), 0);
    checkOutput({tag, "_pkt"},   32'(pkt_count), 0);
    checkOutput({tag, "_err"},   32'(timeout_err), 0);
  endtask

  // Reference model state: channel-indexed arrays, with the wait tracked
  // as cycles elapsed since the grant
  bit          m_flag [3];
  int          m_data [3];
  int          m_drop [3];
  bit          m_busy;
  int          m_age;
  int          m_last;
  int          m_pkt;
  bit          m_err;
  logic [2:0]  m_fv;
  logic [15:0] m_fd;

  task automatic modelReset();
    for (int c = 0; c < 3; c++) begin
      m_flag[c] = 0; m_data[c] = 0; m_drop[c] = 0;
    end
    m_busy = 0; m_age = 0; m_last = 2; m_pkt = 0; m_err = 0; m_fv = 0; m_fd = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelStep();
    bit stb [3];
    int din [3];
    int sel;
    int c;
    bit tmo;
    stb[0] = temp_valid; stb[1] = hum_valid; stb[2] = motion_valid;
    din[0] = temp_data;  din[1] = hum_data;  din[2] = motion_data;
    sel = -1;
    tmo = 0;
    if (!m_busy && enable && (m_flag[0] || m_flag[1] || m_flag[2])) begin
      if (motion_priority && m_flag[2]) sel = 2;
      else begin
        for (int k = 1; k <= 3; k++) begin
          c = (m_last + k) % 3;
          if (sel < 0 && m_flag[c]) sel = c;
        end
      end
    end
    m_fv = 3'b000;
    if (sel >= 0) begin
      m_fv   = 3'(1 << sel);
      m_fd   = 16'(m_data[sel]);
      m_last = sel;
      m_busy = 1;
      m_age  = 0;
    end else if (m_busy) begin
      m_age++;
      if (frm_done) begin
        m_busy = 0;
        m_pkt  = m_pkt + 1;
      end else if (m_age == TO) begin
        m_busy = 0;
        tmo    = 1;
      end
    end
    if (tmo) m_err = 1;
    else if (err_clr) m_err = 0;
    for (int ch = 0; ch < 3; ch++) begin
      if (stb[ch]) begin
        if (m_flag[ch] && sel != ch) m_drop[ch] = (m_drop[ch] < 255) ? m_drop[ch] + 1 : 255;
        m_data[ch] = din[ch];
        m_flag[ch] = 1;
      end else if (sel == ch) begin
        m_flag[ch] = 0;
      end
    end
  endtask

  // Main test sequence
  initial begin
    vec_t        tbl [13];
    logic [2:0]  fv;
    logic [15:0] fd;
    logic [2:0]  exp_fv [3];
    n_compared   = 0;
    n_mismatched = 0;

    tbl[0]  = mk(3'b001, 16'h1234, 16'h0000, 16'h0000, 0, 3'b000, 16'h0000, 0, 3'b001, 0);
    tbl[1]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 3'b001, 16'h1234, 1, 3'b000, 0);
    tbl[2]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 3'b000, 16'h1234, 1, 3'b000, 0);
    tbl[3]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 3'b000, 16'h1234, 1, 3'b000, 0);
    tbl[4]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 3'b000, 16'h1234, 1, 3'b000, 0);
    tbl[5]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 3'b000, 16'h1234, 1, 3'b000, 0);
    tbl[6]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 1, 3'b000, 16'h1234, 0, 3'b000, 1);
    tbl[7]  = mk(3'b110, 16'h0000, 16'hABCD, 16'h5555, 0, 3'b000, 16'h1234, 0, 3'b110, 1);
    tbl[8]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 3'b010, 16'hABCD, 1, 3'b100, 1);
    tbl[9]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 1, 3'b000, 16'hABCD, 0, 3'b100, 2);
    tbl[10] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 3'b100, 16'h5555, 1, 3'b000, 2);
    tbl[11] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 1, 3'b000, 16'h5555, 0, 3'b000, 3);
    tbl[12] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 1, 3'b000, 16'h5555, 0, 3'b000, 3);

    // Reset values, then the vector table
    doReset();
    checkResetValues("reset");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("row%0d_fv", i),   32'(frm_valid), 32'(tbl[i].e_fv));
      checkOutput($sformatf("row%0d_fd", i),   32'(frm_data),  32'(tbl[i].e_fd));
      checkOutput($sformatf("row%0d_busy", i), 32'(busy),      32'(tbl[i].e_busy));
      checkOutput($sformatf("row%0d_pend", i), 32'(pending),   32'(tbl[i].e_pend));
      checkOutput($sformatf("row%0d_pkt", i),  32'(pkt_count), 32'(tbl[i].e_pkt));
    end

    // Round-robin: two bursts with all three channels strobed together
    doReset();
    exp_fv[0] = 3'b001; exp_fv[1] = 3'b010; exp_fv[2] = 3'b100;
    for (int b = 0; b < 2; b++) begin
      temp_valid = 1; hum_valid = 1; motion_valid = 1;
      temp_data = 16'h00A0 + 16'(b); hum_data = 16'h00B0 + 16'(b); motion_data = 16'h00C0 + 16'(b);
      tick();
      temp_valid = 0; hum_valid = 0; motion_valid = 0;
      for (int k = 0; k < 3; k++) begin
        waitGrant(fv, fd);
        checkOutput($sformatf("rr_b%0d_g%0d", b, k), 32'(fv), 32'(exp_fv[k]));
        checkOutput($sformatf("rr_b%0d_d%0d", b, k), 32'(fd), 32'(16'h00A0 + 16'(k * 16) + 16'(b)));
        pulseDone();
      end
    end
    checkOutput("rr_pkt", 32'(pkt_count), 6);

    // Motion priority after a temp grant
    doReset();
    motion_priority = 1;
    strobeCh(0, 16'h0011);
    waitGrant(fv, fd);
    checkOutput("prio_first", 32'(fv), 32'(3'b001));
    pulseDone();
    hum_valid = 1; hum_data = 16'h0022; motion_valid = 1; motion_data = 16'h0033;
    tick();
    hum_valid = 0; motion_valid = 0;
    waitGrant(fv, fd);
    checkOutput("prio_motion", 32'(fv), 32'(3'b100));
    checkOutput("prio_motion_d", 32'(fd), 32'h0033);
    pulseDone();
    waitGrant(fv, fd);
    checkOutput("prio_hum", 32'(fv), 32'(3'b010));
    pulseDone();

    // Overwrite while busy: newest sample wins, two drops
    doReset();
    strobeCh(1, 16'h0022);
    waitGrant(fv, fd);
    strobeCh(0, 16'h0001);
    strobeCh(0, 16'h0002);
    strobeCh(0, 16'h0003);
    checkOutput("ovw_drop", 32'(drop_cnt_temp), 2);
    checkOutput("ovw_pend", 32'(pending), 32'(3'b001));
    pulseDone();
    waitGrant(fv, fd);
    checkOutput("ovw_grant", 32'(fv), 32'(3'b001));
    checkOutput("ovw_data", 32'(fd), 32'h0003);
    pulseDone();

    // Drop counter saturation with grants held off
    doReset();
    enable = 0;
    for (int i = 0; i < 300; i++) begin
      temp_valid = 1; temp_data = 16'(i);
      tick();
    end
    temp_valid = 0;
    checkOutput("sat_drop", 32'(drop_cnt_temp), 255);
    checkOutput("sat_pend", 32'(pending), 32'(3'b001));
    checkOutput("sat_fv", 32'(frm_valid), 0);

    // Timeout: busy falls exactly TO cycles after the grant edge
    doReset();
    strobeCh(0, 16'h0077);
    waitGrant(fv, fd);
    repeat (TO - 1) tick();
    checkOutput("to_busy_before", 32'(busy), 1);
    checkOutput("to_err_before", 32'(timeout_err), 0);
    tick();
    checkOutput("to_busy_after", 32'(busy), 0);
    checkOutput("to_err", 32'(timeout_err), 1);
    checkOutput("to_pkt", 32'(pkt_count), 0);
    err_clr = 1;
    tick();
    err_clr = 0;
    checkOutput("to_clr", 32'(timeout_err), 0);
    strobeCh(0, 16'h0078);
    waitGrant(fv, fd);
    repeat (TO - 1) tick();
    err_clr = 1;
    tick();
    err_clr = 0;
    checkOutput("to_clr_vs_timeout", 32'(timeout_err), 1);
    checkOutput("to_busy2", 32'(busy), 0);

    // Enable gating, then reset in the middle of a wait
    doReset();
    enable = 0;
    temp_valid = 1; hum_valid = 1; motion_valid = 1;
    temp_data = 16'h0001; hum_data = 16'h0002; motion_data = 16'h0003;
    tick();
    hum_valid = 0; motion_valid = 0; temp_data = 16'h0004;
    tick();
    temp_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("en_off_fv%0d", i), 32'(frm_valid), 0);
    end
    checkOutput("en_off_pend", 32'(pending), 32'(3'b111));
    checkOutput("en_off_busy", 32'(busy), 0);
    checkOutput("en_off_drop", 32'(drop_cnt_temp), 1);
    enable = 1;
    waitGrant(fv, fd);
    checkOutput("en_on_g0", 32'(fv), 32'(3'b001));
    checkOutput("en_on_d0", 32'(fd), 32'h0004);
    pulseDone();
    waitGrant(fv, fd);
    checkOutput("en_on_g1", 32'(fv), 32'(3'b010));
    checkOutput("midwait_busy", 32'(busy), 1);
    rst_n = 0;
    #1;
    checkResetValues("midwait");
    @(posedge clk);
    #1;
    rst_n = 1;

    // Randomized traffic against the reference model
    doReset();
    modelReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      temp_valid      = ($urandom_range(0, 3) == 0);
      hum_valid       = ($urandom_range(0, 3) == 0);
      motion_valid    = ($urandom_range(0, 3) == 0);
      temp_data       = 16'($urandom);
      hum_data        = 16'($urandom);
      motion_data     = 16'($urandom);
      enable          = ($urandom_range(0, 9) != 0);
      motion_priority = ($urandom_range(0, 2) == 0);
      frm_done        = ($urandom_range(0, 9) < 1);
      err_clr         = ($urandom_range(0, 29) == 0);
      modelStep();
      tick();
      checkOutput("rnd_fv",    32'(frm_valid),       32'(m_fv));
      checkOutput("rnd_fd",    32'(frm_data),        32'(m_fd));
      checkOutput("rnd_busy",  32'(busy),            32'(m_busy));
      checkOutput("rnd_pend",  32'(pending),         32'({m_flag[2], m_flag[1], m_flag[0]}));
      checkOutput("rnd_dropt", 32'(drop_cnt_temp),   32'(m_drop[0]));
      checkOutput("rnd_droph", 32'(drop_cnt_hum),    32'(m_drop[1]));
      checkOutput("rnd_dropm", 32'(drop_cnt_motion), 32'(m_drop[2]));
      checkOutput("rnd_pkt",   32'(pkt_count),       32'(m_pkt & 16'hFFFF));
      checkOutput("rnd_err",   32'(timeout_err),     32'(m_err));
    end
    clearInputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
